// File: rtl/vga_pkg.sv
// Shared constants for the vgatiming controller: register map, CTRL/STATUS
// bit positions, timing width, 640x480@60 default timing and the FSM state type.
package vga_pkg;

  localparam int unsigned TIMING_W = 11;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_TIM  = 8;

  // Register addresses; 0..7 are the pending timing values in output order
  localparam logic [ADDR_W-1:0] ADDR_HSYNCSTART = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_HBPSTART   = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_HVISSTART  = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_HEND       = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_VSYNCSTART = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_VBPSTART   = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_VVISSTART  = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_VEND       = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_CTRL       = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_STATUS     = 4'd9;
  localparam logic [ADDR_W-1:0] ADDR_FRAMECNT   = 4'd10;

  // CTRL bits
  localparam int unsigned CTRL_APPLY   = 0;
  localparam int unsigned CTRL_INTH_EN = 1;
  localparam int unsigned CTRL_INTV_EN = 2;
  localparam int unsigned CTRL_CANCEL  = 3;

  // STATUS bits
  localparam int unsigned STAT_INTH_PEND = 0;
  localparam int unsigned STAT_INTV_PEND = 1;
  localparam int unsigned STAT_CFG_ERR   = 2;
  localparam int unsigned STAT_ARMED     = 3;

  // 640x480@60 default timing
  localparam int unsigned DEF_HSYNCSTART = 16;
  localparam int unsigned DEF_HBPSTART   = 112;
  localparam int unsigned DEF_HVISSTART  = 160;
  localparam int unsigned DEF_HEND       = 799;
  localparam int unsigned DEF_VSYNCSTART = 10;
  localparam int unsigned DEF_VBPSTART   = 12;
  localparam int unsigned DEF_VVISSTART  = 45;
  localparam int unsigned DEF_VEND       = 524;

  typedef enum logic {
    ST_IDLE,
    ST_ARMED
  } ctrlState_t;

  // True when SyncStart < BpStart < VisibleStart < End
  function automatic logic seqOk(input logic [TIMING_W-1:0] syncStart,
                                 input logic [TIMING_W-1:0] bpStart,
                                 input logic [TIMING_W-1:0] visStart,
                                 input logic [TIMING_W-1:0] endVal);
    return (syncStart < bpStart) && (bpStart < visStart) && (visStart < endVal);
  endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Rising-edge detector.
// Ports: i_clk, i_reset (sync, active-high), i_sig (level in),
//        o_rise_c (combinational pulse: i_sig high now, low last cycle).
module vga_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise_c
);

  logic sigPrev;

  // Previous-value flop
  always_ff @(posedge i_clk) begin
    if (i_reset) sigPrev <= 1'b0;
    else         sigPrev <= i_sig;
  end

  assign o_rise_c = i_sig & ~sigPrev;

endmodule

// File: rtl/vgatiming_ctrl.sv
// Configuration and interrupt controller for the vgatiming generator.
// Holds pending (CPU-written) and active (generator-facing) timing copies and
// commits pending->active only at the frame boundary after a checked APPLY.
// Ports: i_clk, i_reset (sync, active-high); bus i_cs/i_we/i_addr/i_dat ->
//        o_dat/o_ack one cycle later; generator i_inth/i_intv; active timing
//        o_h*/o_v* (11 bit); level interrupt o_irq.
module vgatiming_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned P_HSYNCSTART = DEF_HSYNCSTART,
  parameter int unsigned P_HBPSTART   = DEF_HBPSTART,
  parameter int unsigned P_HVISSTART  = DEF_HVISSTART,
  parameter int unsigned P_HEND       = DEF_HEND,
  parameter int unsigned P_VSYNCSTART = DEF_VSYNCSTART,
  parameter int unsigned P_VBPSTART   = DEF_VBPSTART,
  parameter int unsigned P_VVISSTART  = DEF_VVISSTART,
  parameter int unsigned P_VEND       = DEF_VEND
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cs,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_dat,
  output logic [DATA_W-1:0]   o_dat,
  output logic                o_ack,
  input  logic                i_inth,
  input  logic                i_intv,
  output logic [TIMING_W-1:0] o_hSyncStart,
  output logic [TIMING_W-1:0] o_hBpStart,
  output logic [TIMING_W-1:0] o_hVisibleStart,
  output logic [TIMING_W-1:0] o_hEnd,
  output logic [TIMING_W-1:0] o_vSyncStart,
  output logic [TIMING_W-1:0] o_vBpStart,
  output logic [TIMING_W-1:0] o_vVisibleStart,
  output logic [TIMING_W-1:0] o_vEnd,
  output logic                o_irq
);

  localparam logic [TIMING_W-1:0] RST_VAL [NUM_TIM] = '{
    TIMING_W'(P_HSYNCSTART), TIMING_W'(P_HBPSTART),
    TIMING_W'(P_HVISSTART),  TIMING_W'(P_HEND),
    TIMING_W'(P_VSYNCSTART), TIMING_W'(P_VBPSTART),
    TIMING_W'(P_VVISSTART),  TIMING_W'(P_VEND)
  };

  logic [TIMING_W-1:0] pendReg [NUM_TIM];
  logic [TIMING_W-1:0] actReg  [NUM_TIM];
  logic                inthEn, intvEn;
  logic                inthPend, intvPend, cfgErr;
  logic [DATA_W-1:0]   frameCnt;
  ctrlState_t          state, stateNext;
  logic                commitOk, commitErr;
  logic                intvRise, fb;
  logic                wrEn, ctrlWr, statusWr, applyReq, cancelReq;
  logic [DATA_W-1:0]   rdData;
  logic                unusedDat;

  assign fb        = i_inth & i_intv;
  assign wrEn      = i_cs & i_we;
  assign ctrlWr    = wrEn && (i_addr == ADDR_CTRL);
  assign statusWr  = wrEn && (i_addr == ADDR_STATUS);
  assign applyReq  = ctrlWr & i_dat[CTRL_APPLY];
  assign cancelReq = ctrlWr & i_dat[CTRL_CANCEL];
  assign unusedDat = ^i_dat[DATA_W-1:TIMING_W];

  vga_edge_detect uIntvEdge (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_sig    (i_intv),
    .o_rise_c (intvRise)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= stateNext;
  end

  // FSM next state and commit decision; CANCEL beats both APPLY and fb
  always_comb begin
    stateNext = state;
    commitOk  = 1'b0;
    commitErr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (applyReq && !cancelReq) stateNext = ST_ARMED;
      end
      ST_ARMED: begin
        if (cancelReq) begin
          stateNext = ST_IDLE;
        end else if (fb) begin
          stateNext = ST_IDLE;
          if (seqOk(pendReg[0], pendReg[1], pendReg[2], pendReg[3]) &&
              seqOk(pendReg[4], pendReg[5], pendReg[6], pendReg[7]))
            commitOk = 1'b1;
          else
            commitErr = 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Pending timing registers (addresses 0..7)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_TIM; i++) pendReg[i] <= RST_VAL[i];
    end else if (wrEn && !i_addr[3]) begin
      pendReg[i_addr[2:0]] <= i_dat[TIMING_W-1:0];
    end
  end

  // Active timing registers, loaded on the fb edge so the next frame uses them
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_TIM; i++) actReg[i] <= RST_VAL[i];
    end else if (commitOk) begin
      for (int i = 0; i < NUM_TIM; i++) actReg[i] <= pendReg[i];
    end
  end

  // CTRL enables, STATUS sticky bits (set wins over W1C), frame counter, irq
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      inthEn   <= 1'b0;
      intvEn   <= 1'b0;
      inthPend <= 1'b0;
      intvPend <= 1'b0;
      cfgErr   <= 1'b0;
      frameCnt <= '0;
      o_irq    <= 1'b0;
    end else begin
      if (ctrlWr) begin
        inthEn <= i_dat[CTRL_INTH_EN];
        intvEn <= i_dat[CTRL_INTV_EN];
      end
      inthPend <= i_inth    | (inthPend & ~(statusWr & i_dat[STAT_INTH_PEND]));
      intvPend <= intvRise  | (intvPend & ~(statusWr & i_dat[STAT_INTV_PEND]));
      cfgErr   <= commitErr | (cfgErr   & ~(statusWr & i_dat[STAT_CFG_ERR]));
      if (fb) frameCnt <= frameCnt + 16'd1;
      o_irq <= (inthPend & inthEn) | (intvPend & intvEn);
    end
  end

  // Read mux, sampled before this cycle's write side effects
  always_comb begin
    rdData = '0;
    if (!i_addr[3]) begin
      rdData = DATA_W'(pendReg[i_addr[2:0]]);
    end else begin
      case (i_addr)
        ADDR_CTRL: begin
          rdData[CTRL_APPLY]   = (state == ST_ARMED);
          rdData[CTRL_INTH_EN] = inthEn;
          rdData[CTRL_INTV_EN] = intvEn;
        end
        ADDR_STATUS: begin
          rdData[STAT_INTH_PEND] = inthPend;
          rdData[STAT_INTV_PEND] = intvPend;
          rdData[STAT_CFG_ERR]   = cfgErr;
          rdData[STAT_ARMED]     = (state == ST_ARMED);
        end
        ADDR_FRAMECNT: rdData = frameCnt;
        default: rdData = '0;
      endcase
    end
  end

  // Bus response: ack and data one cycle after the strobe; data is 0 on writes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ack <= 1'b0;
      o_dat <= '0;
    end else begin
      o_ack <= i_cs;
      o_dat <= (i_cs && !i_we) ? rdData : '0;
    end
  end

  assign o_hSyncStart    = actReg[0];
  assign o_hBpStart      = actReg[1];
  assign o_hVisibleStart = actReg[2];
  assign o_hEnd          = actReg[3];
  assign o_vSyncStart    = actReg[4];
  assign o_vBpStart      = actReg[5];
  assign o_vVisibleStart = actReg[6];
  assign o_vEnd          = actReg[7];

endmodule
